editor_campos: RTL and testbench

EDITOR_CAMPOS -- requirements
Module: editor_campos

---
 rtl/editor_campos_pkg.sv | 108 ++++++++++
 rtl/editor_campos_bcd_incdec.sv | 52 +++++
 rtl/editor_campos.sv | 182 ++++++++++++++++++
 tb/tb_editor_campos.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/editor_campos_pkg.sv
`default_nettype none
// ============================================================================
// Module   : editor_campos_pkg
// Purpose  : Shared definitions for the field editor. Includes the pointer
//            codes, the RTC register addresses, the per-field BCD limits and
//            reset values, and the write FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package editor_campos_pkg;

  // Field codes delivered by the pointer FSM.
  localparam logic [3:0] PTR_NONE    = 4'd0;
  localparam logic [3:0] PTR_CLK_SEG = 4'd1;
  localparam logic [3:0] PTR_CLK_MIN = 4'd2;
  localparam logic [3:0] PTR_CLK_HR  = 4'd3;
  localparam logic [3:0] PTR_DIA     = 4'd4;
  localparam logic [3:0] PTR_MES     = 4'd5;
  localparam logic [3:0] PTR_YEAR    = 4'd6;
  localparam logic [3:0] PTR_TMR_SEG = 4'd7;
  localparam logic [3:0] PTR_TMR_MIN = 4'd8;
  localparam logic [3:0] PTR_TMR_HR  = 4'd9;

  localparam int NUM_FIELDS = 9;

  // RTC register addresses.
  localparam logic [7:0] ADDR_CLK_SEG = 8'h21;
  localparam logic [7:0] ADDR_CLK_MIN = 8'h22;
  localparam logic [7:0] ADDR_CLK_HR  = 8'h23;
  localparam logic [7:0] ADDR_DIA     = 8'h24;
  localparam logic [7:0] ADDR_MES     = 8'h25;
  localparam logic [7:0] ADDR_YEAR    = 8'h26;
  localparam logic [7:0] ADDR_TMR_SEG = 8'h41;
  localparam logic [7:0] ADDR_TMR_MIN = 8'h42;
  localparam logic [7:0] ADDR_TMR_HR  = 8'h43;

  // BCD limits, inclusive.
  localparam logic [7:0] BCD_MS_MIN   = 8'h00;  // seconds / minutes
  localparam logic [7:0] BCD_MS_MAX   = 8'h59;
  localparam logic [7:0] BCD_HR_MIN   = 8'h00;
  localparam logic [7:0] BCD_HR_MAX   = 8'h23;
  localparam logic [7:0] BCD_DIA_MIN  = 8'h01;
  localparam logic [7:0] BCD_DIA_MAX  = 8'h31;
  localparam logic [7:0] BCD_MES_MIN  = 8'h01;
  localparam logic [7:0] BCD_MES_MAX  = 8'h12;
  localparam logic [7:0] BCD_YEAR_MIN = 8'h00;
  localparam logic [7:0] BCD_YEAR_MAX = 8'h99;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'h9;

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    ESCRIBIR     = 2'd1,
    ESPERA_LIBRE = 2'd2
  } estado_e;

  function automatic logic ptr_valid(input logic [3:0] p);
    return (p != PTR_NONE) && (p <= PTR_TMR_HR);
  endfunction

  function automatic logic [7:0] ptr_addr(input logic [3:0] p);
    logic [7:0] a;
    case (p)
      PTR_CLK_SEG: a = ADDR_CLK_SEG;
      PTR_CLK_MIN: a = ADDR_CLK_MIN;
      PTR_CLK_HR:  a = ADDR_CLK_HR;
      PTR_DIA:     a = ADDR_DIA;
      PTR_MES:     a = ADDR_MES;
      PTR_YEAR:    a = ADDR_YEAR;
      PTR_TMR_SEG: a = ADDR_TMR_SEG;
      PTR_TMR_MIN: a = ADDR_TMR_MIN;
      PTR_TMR_HR:  a = ADDR_TMR_HR;
      default:     a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] ptr_min(input logic [3:0] p);
    logic [7:0] m;
    case (p)
      PTR_CLK_HR, PTR_TMR_HR: m = BCD_HR_MIN;
      PTR_DIA:                m = BCD_DIA_MIN;
      PTR_MES:                m = BCD_MES_MIN;
      PTR_YEAR:               m = BCD_YEAR_MIN;
      default:                m = BCD_MS_MIN;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] ptr_max(input logic [3:0] p);
    logic [7:0] m;
    case (p)
      PTR_CLK_HR, PTR_TMR_HR: m = BCD_HR_MAX;
      PTR_DIA:                m = BCD_DIA_MAX;
      PTR_MES:                m = BCD_MES_MAX;
      PTR_YEAR:               m = BCD_YEAR_MAX;
      default:                m = BCD_MS_MAX;
    endcase
    return m;
  endfunction

  // Every field powers up at its minimum (0x00, or 0x01 for dia/mes).
  function automatic logic [7:0] ptr_reset(input logic [3:0] p);
    return ptr_min(p);
  endfunction

endpackage : editor_campos_pkg
`default_nettype wire

// File: rtl/editor_campos_bcd_incdec.sv
`default_nettype none
// ============================================================================
// Module   : bcd_incdec
// Purpose  : Steps a two-digit BCD value by +/-1 inside [min, max] and wraps
//            at the ends. Each digit is handled separately, so no binary
//            intermediate value is ever formed.
// Ports    : val_i  [7:0] current BCD value (assumed within [min_i, max_i])
//            min_i  [7:0] lowest legal BCD value
//            max_i  [7:0] highest legal BCD value
//            up_i         1 = increment, 0 = decrement
//            res_o  [7:0] stepped, wrapped BCD value
// Revision : 1.0 - initial release
// ============================================================================
module bcd_incdec
  import editor_campos_pkg::*;
(
  input  logic [7:0] val_i,
  input  logic [7:0] min_i,
  input  logic [7:0] max_i,
  input  logic       up_i,
  output logic [7:0] res_o
);

  logic [3:0] w_hi;
  logic [3:0] w_lo;

  assign w_hi = val_i[7:4];
  assign w_lo = val_i[3:0];

  always_comb begin
    res_o = val_i;
    if (up_i) begin
      if (val_i == max_i) begin
        res_o = min_i;
      end else if (w_lo == BCD_DIGIT_MAX) begin
        res_o = {w_hi + 4'd1, 4'd0};       // carry into the tens digit
      end else begin
        res_o = {w_hi, w_lo + 4'd1};
      end
    end else begin
      if (val_i == min_i) begin
        res_o = max_i;
      end else if (w_lo == 4'd0) begin
        res_o = {w_hi - 4'd1, BCD_DIGIT_MAX}; // borrow from the tens digit
      end else begin
        res_o = {w_hi, w_lo - 4'd1};
      end
    end
  end

endmodule : bcd_incdec
`default_nettype wire

// File: rtl/editor_campos.sv
`default_nettype none
// ============================================================================
// Module   : editor_campos
// Purpose  : Edits nine BCD clock/date/timer fields with up/down buttons.
//            Each accepted step is written to the RTC bus with a
//            request/acknowledge handshake. The handshake has a timeout.
// Ports    : clk          system clock, rising edge
//            reset        synchronous active-high reset
//            interr       edit enable (0 = editing disabled, aborts writes)
//            puntero [3:0] selected field code (1..9 valid)
//            arriba       increment button level (debounced)
//            abajo        decrement button level (debounced)
//            wr_ack       RTC bus write acknowledge
//            wr_req       RTC bus write request
//            dir    [7:0] RTC write address
//            dato   [7:0] RTC write data (BCD)
//            dato_sel [7:0] BCD value of the selected field
//            ocupado      FSM busy (not in REPOSO)
// Revision : 1.0 - initial release
// ============================================================================
module editor_campos
  import editor_campos_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       interr,
  input  logic [3:0] puntero,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       wr_ack,
  output logic       wr_req,
  output logic [7:0] dir,
  output logic [7:0] dato,
  output logic [7:0] dato_sel,
  output logic       ocupado
);

  // The counter runs 0..ACK_TIMEOUT-1. Abort happens on the cycle it would
  // reach ACK_TIMEOUT, so wr_req stays high for exactly ACK_TIMEOUT cycles.
  localparam int              CNT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  estado_e          state_q, state_d;
  logic             wr_req_q, wr_req_d;
  logic [7:0]       dir_q, dir_d;
  logic [7:0]       dato_q, dato_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fld_q [1:NUM_FIELDS];
  logic [7:0]       fld_d [1:NUM_FIELDS];

  // Button history: *_q holds the most recent sample, *_prev_q the one before.
  logic             arriba_q, arriba_prev_q;
  logic             abajo_q, abajo_prev_q;

  logic             ev_up, ev_dn, ev_one;
  logic             ptr_ok;
  logic             accept;
  logic [7:0]       sel_val;
  logic [7:0]       step_res;

  assign ev_up  = arriba_q & ~arriba_prev_q;
  assign ev_dn  = abajo_q & ~abajo_prev_q;
  // Exactly one event. A press of both buttons in the same cycle cancels.
  assign ev_one = ev_up ^ ev_dn;
  assign ptr_ok = ptr_valid(puntero);
  assign accept = (state_q == REPOSO) && interr && ptr_ok && ev_one;

  // Selected field value. The loop keeps codes 0 and 10..15 from reaching
  // the array, and those codes read as 0x00.
  always_comb begin
    sel_val = 8'h00;
    for (int i = 1; i <= NUM_FIELDS; i++) begin
      if (puntero == 4'(i)) begin
        sel_val = fld_q[i];
      end
    end
  end

  bcd_incdec u_bcd_incdec (
    .val_i (sel_val),
    .min_i (ptr_min(puntero)),
    .max_i (ptr_max(puntero)),
    .up_i  (ev_up),
    .res_o (step_res)
  );

  always_comb begin
    state_d  = state_q;
    wr_req_d = wr_req_q;
    dir_d    = dir_q;
    dato_d   = dato_q;
    cnt_d    = cnt_q;
    fld_d    = fld_q;

    if (!interr) begin
      // Leaving edit mode aborts any write in flight. Fields keep their values.
      state_d  = REPOSO;
      wr_req_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        REPOSO: begin
          if (accept) begin
            for (int i = 1; i <= NUM_FIELDS; i++) begin
              if (puntero == 4'(i)) begin
                fld_d[i] = step_res;
              end
            end
            dir_d    = ptr_addr(puntero);
            dato_d   = step_res;
            wr_req_d = 1'b1;
            cnt_d    = '0;
            state_d  = ESCRIBIR;
          end
        end
        ESCRIBIR: begin
          if (wr_ack) begin
            wr_req_d = 1'b0;
            cnt_d    = '0;
            state_d  = ESPERA_LIBRE;
          end else if (cnt_q == CNT_LAST) begin
            wr_req_d = 1'b0;
            cnt_d    = '0;
            state_d  = REPOSO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ESPERA_LIBRE: begin
          if (!wr_ack) begin
            state_d = REPOSO;
          end
        end
        default: begin
          state_d  = REPOSO;
          wr_req_d = 1'b0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= REPOSO;
      wr_req_q      <= 1'b0;
      dir_q         <= 8'h00;
      dato_q        <= 8'h00;
      cnt_q         <= '0;
      arriba_q      <= 1'b0;
      arriba_prev_q <= 1'b0;
      abajo_q       <= 1'b0;
      abajo_prev_q  <= 1'b0;
      for (int i = 1; i <= NUM_FIELDS; i++) begin
        fld_q[i] <= ptr_reset(4'(i));
      end
    end else begin
      state_q       <= state_d;
      wr_req_q      <= wr_req_d;
      dir_q         <= dir_d;
      dato_q        <= dato_d;
      cnt_q         <= cnt_d;
      arriba_q      <= arriba;
      arriba_prev_q <= arriba_q;
      abajo_q       <= abajo;
      abajo_prev_q  <= abajo_q;
      for (int i = 1; i <= NUM_FIELDS; i++) begin
        fld_q[i] <= fld_d[i];
      end
    end
  end

  assign wr_req   = wr_req_q;
  assign dir      = dir_q;
  assign dato     = dato_q;
  assign dato_sel = sel_val;
  assign ocupado  = (state_q != REPOSO);

endmodule : editor_campos
`default_nettype wire

// File: tb/tb_editor_campos.sv
`default_nettype none
// ============================================================================
// Module   : tb_editor_campos
// Purpose  : Self-checking bench for editor_campos. Expected writes are queued
//            when a press is driven and compared when wr_req rises. Field
//            values are tracked by an independent decimal model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_editor_campos;

  logic       clk = 1'b0;
  logic       reset, interr, arriba, abajo, wr_ack;
  logic [3:0] puntero;
  logic       wr_req, ocupado;
  logic [7:0] dir, dato, dato_sel;

  int checks   = 0;
  int failures = 0;
  int writes   = 0;
  int hi_len   = 0;
  int last_len = 0;
  logic prev_wr = 1'b0;

  logic [15:0] sb [$];          // expected {dir, dato} per write
  logic [7:0]  exp_fld [1:9];

  editor_campos #(.ACK_TIMEOUT(255)) dut (
    .clk      (clk),
    .reset    (reset),
    .interr   (interr),
    .puntero  (puntero),
    .arriba   (arriba),
    .abajo    (abajo),
    .wr_ack   (wr_ack),
    .wr_req   (wr_req),
    .dir      (dir),
    .dato     (dato),
    .dato_sel (dato_sel),
    .ocupado  (ocupado)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int b2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic logic [7:0] i2b(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  function automatic int fmin(input int p);
    return (p == 4 || p == 5) ? 1 : 0;
  endfunction
  function automatic int fmax(input int p);
    case (p)
      3, 9:    return 23;
      4:       return 31;
      5:       return 12;
      6:       return 99;
      default: return 59;
    endcase
  endfunction
  function automatic logic [7:0] faddr(input int p);
    return (p <= 6) ? 8'(8'h20 + p) : 8'(8'h40 + p - 6);
  endfunction
  function automatic logic [7:0] model_step(input int p, input bit up);
    int v;
    v = b2i(exp_fld[p]);
    if (up) v = (v == fmax(p)) ? fmin(p) : v + 1;
    else    v = (v == fmin(p)) ? fmax(p) : v - 1;
    return i2b(v);
  endfunction
  task automatic model_reset();
    for (int i = 1; i <= 9; i++) exp_fld[i] = (i == 4 || i == 5) ? 8'h01 : 8'h00;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: compare each new request against the scoreboard.
  always @(negedge clk) begin
    if (wr_req === 1'b1 && prev_wr === 1'b0) begin
      writes++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write: observed dir=%0h dato=%0h expected no write", dir, dato);
      end
      if (sb.size() != 0) begin
        logic [15:0] e;
        e = sb.pop_front();
        checks++;
        assert ({dir, dato} === e) else begin
          failures++;
          $error("FAIL write_dir_dato: observed=%0h expected=%0h", {dir, dato}, e);
        end
      end
    end
    if (wr_req === 1'b1) hi_len++;
    else if (hi_len != 0) begin
      last_len = hi_len;
      hi_len   = 0;
    end
    prev_wr = wr_req;
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input bit up, input bit dn);
    @(posedge clk); #1;
    arriba = up; abajo = dn;
    @(posedge clk); #1;
    arriba = 1'b0; abajo = 1'b0;
  endtask

  task automatic wait_wr_rise();
    int n = 0;
    while (wr_req !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("wr_req_rise", 32'(wr_req), 32'd1);
    chk("ocupado_busy", 32'(ocupado), 32'd1);
  endtask

  task automatic ack_handshake(input int delay);
    int n = 0;
    repeat (delay) @(posedge clk);
    #1 wr_ack = 1'b1;
    while (wr_req !== 1'b0 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("wr_req_drop_ack", 32'(wr_req), 32'd0);
    chk("ocupado_espera", 32'(ocupado), 32'd1);
    @(posedge clk); #1 wr_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ocupado_idle", 32'(ocupado), 32'd0);
  endtask

  task automatic do_edit(input int p, input bit up, input int delay);
    puntero = 4'(p);
    exp_fld[p] = model_step(p, up);
    sb.push_back({faddr(p), exp_fld[p]});
    press(up, !up);
    wait_wr_rise();
    ack_handshake(delay);
    chk("dato_sel_after_edit", 32'(dato_sel), 32'(exp_fld[p]));
  endtask

  task automatic check_all_sel(input string tag);
    for (int p = 0; p < 16; p++) begin
      puntero = 4'(p);
      #1;
      chk(tag, 32'(dato_sel), (p >= 1 && p <= 9) ? 32'(exp_fld[p]) : 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0;
    int n;
    reset = 1'b1; interr = 1'b1; arriba = 1'b0; abajo = 1'b0;
    wr_ack = 1'b0; puntero = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset_wr_req", 32'(wr_req), 32'd0);
    chk("reset_dir", 32'(dir), 32'd0);
    chk("reset_dato", 32'(dato), 32'd0);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    check_all_sel("reset_dato_sel");

    // First write, ack held off: four cycles of wr_req
    do_edit(1, 1'b1, 3);
    chk("ack_wr_req_len", 32'(last_len), 32'd4);

    // Wrap and BCD boundaries
    do_edit(3, 1'b0, 1);  // 00 -> 23
    do_edit(3, 1'b1, 1);  // 23 -> 00
    do_edit(5, 1'b0, 1);  // 01 -> 12, addr 0x25
    do_edit(4, 1'b0, 1);  // 01 -> 31
    do_edit(4, 1'b1, 1);  // 31 -> 01
    do_edit(6, 1'b0, 1);  // 00 -> 99
    do_edit(6, 1'b1, 1);  // 99 -> 00
    do_edit(2, 1'b0, 1);  // 00 -> 59
    do_edit(7, 1'b1, 1);  // 00 -> 01, addr 0x41
    do_edit(2, 1'b1, 1);  // 59 -> 00

    // Both buttons in the same cycle
    w0 = writes;
    puntero = 4'd2;
    press(1'b1, 1'b1);
    repeat (6) @(negedge clk);
    chk("both_no_write", 32'(writes), 32'(w0));
    chk("both_field_kept", 32'(dato_sel), 32'(exp_fld[2]));

    // No acknowledge: abort after the timeout, field keeps its new value
    puntero = 4'd8;
    exp_fld[8] = model_step(8, 1'b1);
    sb.push_back({faddr(8), exp_fld[8]});
    press(1'b1, 1'b0);
    wait_wr_rise();
    n = 0;
    while (wr_req !== 1'b0 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("timeout_wr_req_drop", 32'(wr_req), 32'd0);
    chk("timeout_ocupado", 32'(ocupado), 32'd0);
    @(negedge clk);
    chk("timeout_len", 32'(last_len), 32'd255);
    chk("timeout_field_kept", 32'(dato_sel), 32'(exp_fld[8]));
    do_edit(8, 1'b1, 1);  // next press is accepted

    // Press during ESCRIBIR is dropped
    w0 = writes;
    puntero = 4'd9;
    exp_fld[9] = model_step(9, 1'b1);
    sb.push_back({faddr(9), exp_fld[9]});
    press(1'b1, 1'b0);
    wait_wr_rise();
    press(1'b1, 1'b0);
    ack_handshake(1);
    repeat (4) @(negedge clk);
    chk("busy_press_one_write", 32'(writes), 32'(w0 + 1));
    chk("busy_press_field", 32'(dato_sel), 32'(exp_fld[9]));

    // Invalid pointer
    w0 = writes;
    puntero = 4'd0;
    press(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("ptr0_no_write", 32'(writes), 32'(w0));
    chk("ptr0_dato_sel", 32'(dato_sel), 32'd0);
    check_all_sel("ptr0_fields_kept");

    // interr dropped mid-write, then a press with editing disabled
    puntero = 4'd1;
    exp_fld[1] = model_step(1, 1'b1);
    sb.push_back({faddr(1), exp_fld[1]});
    press(1'b1, 1'b0);
    wait_wr_rise();
    @(posedge clk); #1 interr = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("interr_wr_req", 32'(wr_req), 32'd0);
    chk("interr_ocupado", 32'(ocupado), 32'd0);
    chk("interr_field_kept", 32'(dato_sel), 32'(exp_fld[1]));
    w0 = writes;
    press(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("interr0_no_write", 32'(writes), 32'(w0));
    chk("interr0_field", 32'(dato_sel), 32'(exp_fld[1]));

    // Reset restores field values
    @(posedge clk); #1 reset = 1'b1; interr = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst2_wr_req", 32'(wr_req), 32'd0);
    chk("rst2_dir", 32'(dir), 32'd0);
    chk("rst2_dato", 32'(dato), 32'd0);
    model_reset();
    check_all_sel("rst2_dato_sel");
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_no_wr_req", 32'(wr_req), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_editor_campos
`default_nettype wire
